dpll_phase_filter: RTL and testbench
====================================

# dpll_phase_filter

Upstream control stage of the DPLL loop. Compares rising edges of the external reference against the divider's feedback output and classifies each edge pair as lag, lead or coincident. Decisions are integrated in a signed random-walk (K-counter) loop filter, which emits the one-cycle `positiveShift`/`negativeShift` pulses that drive the programmable divider's phase correction. Also reports a coarse lock indication.

## Interface
- `CNT_WIDTH`, 8: width of the signed filter accumulator; threshold is `CNT_WIDTH-1` bits.
- `WINDOW_WIDTH`, 8: width of the partner-edge wait counter.
- `LOCK_COUNT`, 16: consecutive decisions without a shift pulse required for lock.
- `clk_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  filter enable, synchronous to `clk_i`.
- `ref_i`  in  1  external reference; asynchronous to `clk_i`.
- `fb_i`  in  1  divider output (feedback), `clk_i` domain.
- `threshold_i`  in  CNT_WIDTH-1  filter threshold K (unsigned); 0 is treated as 1.
- `window_i`  in  WINDOW_WIDTH  maximum cycles to wait for the partner edge.
- `positiveShift_o`  out  1  one-cycle pulse: feedback lags, so the divider must advance.
- `negativeShift_o`  out  1  one-cycle pulse: feedback leads, so the divider must retard.
- `lock_o`  out  1  lock indication.

## Operation
- **Reset** (`reset_i`=1, asynchronous): all synchronizer flops 0, state IDLE, accumulator 0, wait counter 0, lock streak 0. All outputs 0.
- **Input path.** `ref_i` and `fb_i` each pass through identical 2-flop synchronizers plus one history flop. This keeps their relative alignment. A rise flag is `s2 & !s3`.
- **FSM states:** IDLE, WAIT_FB (ref seen first), WAIT_REF (fb seen first).
- **IDLE transitions:**
  - Both rises in the same cycle: COINCIDENT decision; stay in IDLE.
  - Ref rise only: go to WAIT_FB and clear the wait counter.
  - Fb rise only: go to WAIT_REF and clear the wait counter.
- **WAIT_FB transitions:**
  - Fb rise: LAG decision; go to IDLE.
  - Ref rise (with or without fb rise): LAG decision; stay in WAIT_FB and clear the wait counter. This handles a slip or a new pending edge.
  - No edge and wait counter == `window_i`: LAG decision (timeout); go to IDLE.
  - Otherwise: increment the wait counter.
- **WAIT_REF transitions:** mirror of WAIT_FB with LEAD decisions.
- **Priority:** a partner edge takes priority over timeout in the same cycle. With `window_i`=0, the timeout fires in the cycle after entry.
- **Filter.** Signed accumulator `acc` of CNT_WIDTH bits; let Keff = max(`threshold_i`, 1).
  - LAG: if `acc+1` == +Keff, pulse `positiveShift_o` and set `acc` to 0; else `acc` += 1.
  - LEAD: if `acc-1` == -Keff, pulse `negativeShift_o` and set `acc` to 0; else `acc` -= 1.
  - COINCIDENT: `acc` unchanged.
  - `acc` never exceeds ±(2^(CNT_WIDTH-1)-1), so no overflow handling is needed.
  - The two pulses are mutually exclusive and never high in consecutive cycles from a single decision.
- **Lock.**
  - Streak counter increments on each decision that produces no pulse, saturating at LOCK_COUNT.
  - A shift pulse or any timeout decision clears the streak.
  - `lock_o` = (streak == LOCK_COUNT), registered.
- **Enable.** `enable_i`=0 forces IDLE and clears `acc`, the wait counter, the streak and all outputs. Rise flags are ignored; synchronizers keep running. On re-enable, the first rise seen is treated as a fresh event.
- **`threshold_i` / `window_i` changes** take effect at the next decision or comparison. If `acc` is already past the new threshold, the next decision in the same direction still compares for equality only. The accumulator resets to 0 only on exact match. Software must change the threshold only while `enable_i`=0.

## Timing
- Let E be the `clk_i` edge at which a rise is first captured in synchronizer stage 1. The rise flag is valid in the cycle after E+1. The decision, `acc` update and registered output pulse all occur at E+2, so the pulse is high from E+2 to E+3.
- Shift pulses are exactly one cycle wide.
- `lock_o` updates at the same edge as the decision that completes the streak or clears it.
- No handshake: the divider must accept a pulse in any cycle.

## Test plan
- **Reset and enable:** assert `reset_i` mid-WAIT_FB with `acc`=2. All outputs go 0 immediately. After release, the first fb rise enters WAIT_REF and `acc` = 0.
- **Lag integration:** K=3, window=20; ref rises 2 cycles before fb on 3 periods. Exactly one `positiveShift_o` pulse at E+2 of the third fb rise; `acc` returns to 0.
- **Lead integration:** K=1; fb rises 4 cycles before ref. A `negativeShift_o` pulse on every period, never `positiveShift_o`.
- **Timeout:** window=5; ref rises with `fb_i` held low. LAG decision after 5 counts in WAIT_FB; the streak is cleared.
- **Coincidence and lock:** LOCK_COUNT=16; identical ref/fb edges for 16 periods. `lock_o` rises at the 16th decision. One forced lag pulse (K=1) drops `lock_o` at the pulse edge.
- **Simultaneous edges in WAIT_FB:** both rise 3 cycles after the ref rise. One LAG decision; state stays WAIT_FB with the wait counter at 0.

Source files
------------

// File: rtl/dpll_phase_filter.sv
// DPLL phase detector and K-counter loop filter.
// Classifies ref/fb edge pairs and emits divider phase-shift pulses plus lock status.
module dpll_phase_filter #(
    parameter int CNT_WIDTH    = 8,
    parameter int WINDOW_WIDTH = 8,
    parameter int LOCK_COUNT   = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    ref_i,
    input  logic                    fb_i,
    input  logic [CNT_WIDTH-2:0]    threshold_i,
    input  logic [WINDOW_WIDTH-1:0] window_i,
    output logic                    positiveShift_o,
    output logic                    negativeShift_o,
    output logic                    lock_o
);

    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic signed [CNT_WIDTH-1:0] ACC_ONE = CNT_WIDTH'(1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FB  = 2'd1,
        WAIT_REF = 2'd2
    } state_t;

    logic r_ref_s1, r_ref_s2, r_ref_s3;
    logic r_fb_s1, r_fb_s2, r_fb_s3;

    state_t                       r_state;
    logic signed [CNT_WIDTH-1:0]  r_acc;
    logic [WINDOW_WIDTH-1:0]      r_wcnt;
    logic [LW-1:0]                r_streak;
    logic                         r_pos;
    logic                         r_neg;
    logic                         r_lock;

    logic                         w_ref_rise;
    logic                         w_fb_rise;
    state_t                       w_state_nxt;
    logic [WINDOW_WIDTH-1:0]      w_wcnt_nxt;
    logic                         w_lag;
    logic                         w_lead;
    logic                         w_coin;
    logic                         w_tmo;
    logic [CNT_WIDTH-2:0]         w_keff;
    logic signed [CNT_WIDTH-1:0]  w_keff_s;
    logic signed [CNT_WIDTH-1:0]  w_acc_inc;
    logic signed [CNT_WIDTH-1:0]  w_acc_dec;
    logic                         w_pos_hit;
    logic                         w_neg_hit;
    logic signed [CNT_WIDTH-1:0]  w_acc_nxt;
    logic [LW-1:0]                w_streak_nxt;
    logic                         w_lock_nxt;

    // Both inputs share the same synchronizer depth so their relative skew is preserved.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
            r_ref_s3 <= 1'b0;
            r_fb_s1  <= 1'b0;
            r_fb_s2  <= 1'b0;
            r_fb_s3  <= 1'b0;
        end else begin
            r_ref_s1 <= ref_i;
            r_ref_s2 <= r_ref_s1;
            r_ref_s3 <= r_ref_s2;
            r_fb_s1  <= fb_i;
            r_fb_s2  <= r_fb_s1;
            r_fb_s3  <= r_fb_s2;
        end
    end

    assign w_ref_rise = r_ref_s2 & ~r_ref_s3;
    assign w_fb_rise  = r_fb_s2 & ~r_fb_s3;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_lag       = 1'b0;
        w_lead      = 1'b0;
        w_coin      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ref_rise && w_fb_rise) begin
                    w_coin = 1'b1;
                end else if (w_ref_rise) begin
                    w_state_nxt = WAIT_FB;
                    w_wcnt_nxt  = '0;
                end else if (w_fb_rise) begin
                    w_state_nxt = WAIT_REF;
                    w_wcnt_nxt  = '0;
                end
            end
            WAIT_FB: begin
                if (w_ref_rise) begin
                    w_lag      = 1'b1;
                    w_wcnt_nxt = '0;
                end else if (w_fb_rise) begin
                    w_lag       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wcnt == window_i) begin
                    w_lag       = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + WINDOW_WIDTH'(1);
                end
            end
            WAIT_REF: begin
                if (w_fb_rise) begin
                    w_lead     = 1'b1;
                    w_wcnt_nxt = '0;
                end else if (w_ref_rise) begin
                    w_lead      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wcnt == window_i) begin
                    w_lead      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + WINDOW_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!enable_i) begin
            w_state_nxt = IDLE;
            w_wcnt_nxt  = '0;
            w_lag       = 1'b0;
            w_lead      = 1'b0;
            w_coin      = 1'b0;
            w_tmo       = 1'b0;
        end
    end

    // A zero threshold would never match, so it behaves as one.
    assign w_keff    = (threshold_i == '0) ? (CNT_WIDTH-1)'(1) : threshold_i;
    assign w_keff_s  = signed'({1'b0, w_keff});
    assign w_acc_inc = r_acc + ACC_ONE;
    assign w_acc_dec = r_acc - ACC_ONE;
    assign w_pos_hit = w_lag && (w_acc_inc == w_keff_s);
    assign w_neg_hit = w_lead && (w_acc_dec == -w_keff_s);

    always_comb begin
        w_acc_nxt = r_acc;
        if (!enable_i) begin
            w_acc_nxt = '0;
        end else if (w_lag) begin
            w_acc_nxt = w_pos_hit ? '0 : w_acc_inc;
        end else if (w_lead) begin
            w_acc_nxt = w_neg_hit ? '0 : w_acc_dec;
        end
    end

    always_comb begin
        w_streak_nxt = r_streak;
        if (!enable_i || w_pos_hit || w_neg_hit || w_tmo) begin
            w_streak_nxt = '0;
        end else if ((w_lag || w_lead || w_coin) && (r_streak != LOCK_MAX)) begin
            w_streak_nxt = r_streak + LW'(1);
        end
    end

    assign w_lock_nxt = (w_streak_nxt == LOCK_MAX);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wcnt   <= '0;
            r_acc    <= '0;
            r_streak <= '0;
            r_pos    <= 1'b0;
            r_neg    <= 1'b0;
            r_lock   <= 1'b0;
        end else begin
            r_wcnt   <= w_wcnt_nxt;
            r_acc    <= w_acc_nxt;
            r_streak <= w_streak_nxt;
            r_pos    <= w_pos_hit;
            r_neg    <= w_neg_hit;
            r_lock   <= w_lock_nxt;
        end
    end

    assign positiveShift_o = r_pos;
    assign negativeShift_o = r_neg;
    assign lock_o          = r_lock;

endmodule

// File: tb/tb_dpll_phase_filter.sv
// Directed bench for dpll_phase_filter.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_dpll_phase_filter;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       ref_i;
    logic       fb_i;
    logic [6:0] threshold_i;
    logic [7:0] window_i;
    logic       positiveShift_o;
    logic       negativeShift_o;
    logic       lock_o;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pos;
    int n_neg;
    int pos_at;
    int neg_at;

    dpll_phase_filter #(
        .CNT_WIDTH(8),
        .WINDOW_WIDTH(8),
        .LOCK_COUNT(16)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .ref_i(ref_i),
        .fb_i(fb_i),
        .threshold_i(threshold_i),
        .window_i(window_i),
        .positiveShift_o(positiveShift_o),
        .negativeShift_o(negativeShift_o),
        .lock_o(lock_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        ref_i   = 1'b0;
        fb_i    = 1'b0;
        cyc(3);
        reset_i = 1'b0;
        cyc(1);
    endtask

    // Rises ref at cycle tr and fb at cycle tf (negative = none), each held 3 cycles.
    task automatic run_period(input int tr, input int tf, input int len);
        n_pos  = 0;
        n_neg  = 0;
        pos_at = -1;
        neg_at = -1;
        for (int c = 0; c < len; c++) begin
            ref_i = (tr >= 0) && (c >= tr) && (c < tr + 3);
            fb_i  = (tf >= 0) && (c >= tf) && (c < tf + 3);
            cyc(1);
            if (positiveShift_o) begin
                n_pos++;
                pos_at = c;
            end
            if (negativeShift_o) begin
                n_neg++;
                neg_at = c;
            end
        end
        ref_i = 1'b0;
        fb_i  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i     = 1'b1;
        enable_i    = 1'b1;
        ref_i       = 1'b0;
        fb_i        = 1'b0;
        threshold_i = 7'd5;
        window_i    = 8'd50;
        cyc(3);
        chk("rst_pos", positiveShift_o, 0);
        chk("rst_neg", negativeShift_o, 0);
        chk("rst_lock", lock_o, 0);
        chk("rst_acc", dut.r_acc, 0);
        reset_i = 1'b0;
        cyc(2);

        // Reset asserted mid-WAIT_FB with acc = 2
        run_period(0, 2, 8);
        run_period(0, 2, 8);
        chk("pre_acc2", dut.r_acc, 2);
        ref_i = 1'b1;
        cyc(3);
        chk("pre_wait_fb", dut.r_state, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_acc", dut.r_acc, 0);
        chk("async_state", dut.r_state, 0);
        chk("async_pos", positiveShift_o, 0);
        ref_i = 1'b0;
        cyc(3);
        reset_i = 1'b0;
        cyc(1);
        fb_i = 1'b1;
        cyc(3);
        chk("post_rst_wait_ref", dut.r_state, 2);
        chk("post_rst_acc", dut.r_acc, 0);
        fb_i = 1'b0;
        run_period(0, -1, 6);
        chk("lead_acc_m1", dut.r_acc, 32'hFFFF_FFFF);
        enable_i = 1'b0;
        cyc(1);
        chk("dis_acc", dut.r_acc, 0);
        chk("dis_state", dut.r_state, 0);
        enable_i = 1'b1;

        // Lag integration, K=3
        do_reset();
        threshold_i = 7'd3;
        window_i    = 8'd20;
        run_period(0, 2, 8);
        chk("lag_p1_pos", n_pos, 0);
        run_period(0, 2, 8);
        chk("lag_p2_pos", n_pos, 0);
        chk("lag_p2_acc", dut.r_acc, 2);
        run_period(0, 2, 8);
        chk("lag_p3_pos", n_pos, 1);
        chk("lag_p3_at", pos_at, 4);
        chk("lag_p3_neg", n_neg, 0);
        chk("lag_p3_acc", dut.r_acc, 0);

        // Lead integration, K=1
        do_reset();
        threshold_i = 7'd1;
        for (int p = 0; p < 3; p++) begin
            run_period(4, 0, 10);
            chk("lead_neg", n_neg, 1);
            chk("lead_at", neg_at, 6);
            chk("lead_pos", n_pos, 0);
        end

        // Timeout after 5 counts clears the streak
        do_reset();
        threshold_i = 7'd5;
        window_i    = 8'd5;
        run_period(0, 0, 8);
        run_period(0, 0, 8);
        chk("tmo_streak_pre", dut.r_streak, 2);
        ref_i = 1'b1;
        cyc(3);
        ref_i = 1'b0;
        chk("tmo_enter", dut.r_state, 1);
        cyc(5);
        chk("tmo_wcnt", dut.r_wcnt, 5);
        chk("tmo_still_wait", dut.r_state, 1);
        cyc(1);
        chk("tmo_idle", dut.r_state, 0);
        chk("tmo_acc", dut.r_acc, 1);
        chk("tmo_streak", dut.r_streak, 0);
        chk("tmo_pos", positiveShift_o, 0);

        // Coincidence and lock
        do_reset();
        threshold_i = 7'd1;
        window_i    = 8'd20;
        for (int p = 0; p < 15; p++) begin
            run_period(0, 0, 8);
        end
        chk("coin_streak15", dut.r_streak, 15);
        chk("coin_lock15", lock_o, 0);
        chk("coin_acc", dut.r_acc, 0);
        ref_i = 1'b1;
        fb_i  = 1'b1;
        cyc(2);
        chk("lock_before", lock_o, 0);
        cyc(1);
        chk("lock_rise", lock_o, 1);
        ref_i = 1'b0;
        fb_i  = 1'b0;
        cyc(5);
        ref_i = 1'b1;
        cyc(2);
        fb_i = 1'b1;
        cyc(2);
        chk("lock_hold", lock_o, 1);
        chk("lock_hold_pos", positiveShift_o, 0);
        cyc(1);
        chk("lock_pulse_pos", positiveShift_o, 1);
        chk("lock_drop", lock_o, 0);
        chk("lock_pulse_neg", negativeShift_o, 0);
        ref_i = 1'b0;
        fb_i  = 1'b0;
        cyc(1);
        chk("lock_pulse_width", positiveShift_o, 0);
        cyc(4);

        // Simultaneous rises while in WAIT_FB
        do_reset();
        threshold_i = 7'd5;
        window_i    = 8'd20;
        ref_i = 1'b1;
        cyc(1);
        ref_i = 1'b0;
        cyc(2);
        chk("sim_enter", dut.r_state, 1);
        ref_i = 1'b1;
        fb_i  = 1'b1;
        cyc(1);
        ref_i = 1'b0;
        fb_i  = 1'b0;
        cyc(1);
        chk("sim_wcnt_pre", dut.r_wcnt, 2);
        cyc(1);
        chk("sim_state", dut.r_state, 1);
        chk("sim_wcnt", dut.r_wcnt, 0);
        chk("sim_acc", dut.r_acc, 1);
        cyc(1);
        chk("sim_acc_once", dut.r_acc, 1);
        chk("sim_wcnt_run", dut.r_wcnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
